// File: rtl/vscale_regfile_sb_pkg.sv
// Shared widths for the vscale integer register file with scoreboard.
// Mirrors the XPR_LEN / REG_ADDR_WIDTH / REG_NUM values of the rv32 opcode header.
package vscale_regfile_sb_pkg;

    localparam int XPR_LEN        = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_NUM        = 32;
    localparam int NRD_DEFAULT    = 2;

endpackage

// File: rtl/vscale_regfile_sb_if.sv
// Register-file bus: read ports, pipeline writeback (W0), long-latency writeback (W1), scoreboard mark.
// The pipeline side uses the master modport; the register file uses the slave modport.
interface vscale_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic                wen;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                mark_en;
    logic [AW-1:0]       mark_addr;
    logic                lwen;
    logic [AW-1:0]       lwa;
    logic [XLEN-1:0]     lwd;
    logic                wr_conflict;

    modport master (
        output ra, wen, wa, wd, mark_en, mark_addr, lwen, lwa, lwd,
        input  rd, rd_busy, wr_conflict
    );

    modport slave (
        input  ra, wen, wa, wd, mark_en, mark_addr, lwen, lwa, lwd,
        output rd, rd_busy, wr_conflict
    );
endinterface

// File: rtl/vscale_regfile_busy.sv
// Write-pending scoreboard: one busy bit per architectural register, x0 never busy.
// A mark in the same cycle as a clear of the same register wins (new issue beats old writeback).
module vscale_regfile_busy
    import vscale_regfile_sb_pkg::*;
#(
    parameter int NREGS = REG_NUM,
    parameter int AW    = REG_ADDR_WIDTH,
    parameter int NRD   = NRD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mark_en,
    input  logic [AW-1:0]     mark_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    busy
);

    logic [NREGS-1:0] busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (r == 0)
                    busy_q[r] <= 1'b0;
                else if (mark_en && mark_addr == AW'(r))
                    busy_q[r] <= 1'b1;
                else if (clr_en && clr_addr == AW'(r))
                    busy_q[r] <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        assign busy[i] = busy_q[ra[i*AW +: AW]];
    end

endmodule

// File: rtl/vscale_regfile_sb.sv
// Integer register file with N read ports, two write ports and a RAW scoreboard; x0 reads zero.
// Define VSCALE_REGFILE_BYPASS_EN for same-cycle write-through of W0/W1 data onto the read ports.
module vscale_regfile_sb
    import vscale_regfile_sb_pkg::*;
#(
    parameter int XLEN  = XPR_LEN,
    parameter int NREGS = REG_NUM,
    parameter int AW    = REG_ADDR_WIDTH,
    parameter int NRD   = NRD_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    vscale_regfile_sb_if.slave  bus
);

    logic [XLEN-1:0] mem [NREGS];
    logic [NRD-1:0]  sb_busy;
    logic            w0_hit_w1;
    logic            wr_conflict_q;

    assign w0_hit_w1 = bus.wen && bus.lwen && (bus.wa == bus.lwa) && (bus.wa != '0);

    // Data array is deliberately not reset; on a W0/W1 collision the pipeline value is kept.
    always_ff @(posedge clk) begin
        if (bus.wen && bus.wa != '0)
            mem[bus.wa] <= bus.wd;
        if (bus.lwen && bus.lwa != '0 && !w0_hit_w1)
            mem[bus.lwa] <= bus.lwd;
    end

    always_ff @(posedge clk) begin
        if (reset)
            wr_conflict_q <= 1'b0;
        else
            wr_conflict_q <= w0_hit_w1;
    end

    assign bus.wr_conflict = wr_conflict_q;

    vscale_regfile_busy #(
        .NREGS (NREGS),
        .AW    (AW),
        .NRD   (NRD)
    ) u_busy (
        .clk       (clk),
        .reset     (reset),
        .mark_en   (bus.mark_en),
        .mark_addr (bus.mark_addr),
        .clr_en    (bus.lwen),
        .clr_addr  (bus.lwa),
        .ra        (bus.ra),
        .busy      (sb_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = bus.ra[i*AW +: AW];

        always_comb begin
            data = (addr == '0) ? '0 : mem[addr];
            bsy  = sb_busy[i];
`ifdef VSCALE_REGFILE_BYPASS_EN
            // A W1 writeback being consumed this cycle resolves the hazard immediately.
            if (bus.wen && bus.wa == addr && addr != '0) begin
                data = bus.wd;
            end else if (bus.lwen && bus.lwa == addr && addr != '0) begin
                data = bus.lwd;
                bsy  = 1'b0;
            end
`endif
        end

        assign bus.rd[i*XLEN +: XLEN] = data;
        assign bus.rd_busy[i]         = bsy;
    end

endmodule

// File: tb/tb_vscale_regfile_sb.sv
// Randomised self-checking bench for vscale_regfile_sb against a behavioural register-file model.
module tb_vscale_regfile_sb;
    import vscale_regfile_sb_pkg::*;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;
    localparam int NRD   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vscale_regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

    vscale_regfile_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW),
        .NRD   (NRD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] m_data [NREGS];
    bit          m_known [NREGS];
    bit          m_busy [NREGS];
    bit          m_conf;
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ra(input int port, input int a);
        bus.ra[port*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        bus.wen = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.lwen = 1'b0; bus.lwa = '0; bus.lwd = '0;
        bus.mark_en = 1'b0; bus.mark_addr = '0;
    endtask

    // Expected read-side view: architectural state, plus write-through when bypass is built in.
    task automatic check_outputs();
        for (int i = 0; i < NRD; i++) begin
            int          a;
            logic [31:0] ed;
            bit          eb;
            bit          dknown;
            a      = int'(bus.ra[i*AW +: AW]);
            ed     = (a == 0) ? 32'h0 : m_data[a];
            dknown = (a == 0) || m_known[a];
            eb     = (a != 0) && m_busy[a];
`ifdef VSCALE_REGFILE_BYPASS_EN
            if (bus.wen && int'(bus.wa) == a && a != 0) begin
                ed = bus.wd; dknown = 1'b1;
            end else if (bus.lwen && int'(bus.lwa) == a && a != 0) begin
                ed = bus.lwd; dknown = 1'b1; eb = 1'b0;
            end
`endif
            if (dknown)
                chk($sformatf("rd%0d[x%0d]", i, a), bus.rd[i*XLEN +: XLEN], ed);
            chk($sformatf("rd_busy%0d[x%0d]", i, a), 32'(bus.rd_busy[i]), 32'(eb));
        end
        chk("wr_conflict", 32'(bus.wr_conflict), 32'(m_conf));
    endtask

    // Architectural effect of one clock edge.
    task automatic update_model();
        if (bus.lwen && bus.lwa != '0) begin
            m_data[bus.lwa] = bus.lwd; m_known[bus.lwa] = 1'b1;
        end
        if (bus.wen && bus.wa != '0) begin
            m_data[bus.wa] = bus.wd; m_known[bus.wa] = 1'b1;
        end
        if (reset) begin
            for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
            m_conf = 1'b0;
        end else begin
            m_conf = bus.wen && bus.lwen && bus.wa == bus.lwa && bus.wa != '0;
            if (bus.lwen && bus.lwa != '0) m_busy[bus.lwa] = 1'b0;
            if (bus.mark_en && bus.mark_addr != '0) m_busy[bus.mark_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    function automatic int pick_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREGS-1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            m_data[r] = '0; m_known[r] = 1'b0; m_busy[r] = 1'b0;
        end
        m_conf = 1'b0;
        reset  = 1'b1;
        bus.ra = '0;
        idle();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        // Reset state across every register
        for (int r = 0; r < NREGS; r += 2) begin
            set_ra(0, r); set_ra(1, r + 1);
            tick();
        end
        reset = 1'b0;
        bus.ra = '0;
        #1;
        chk("x0_rd0", bus.rd[0 +: XLEN], 32'h0);
        chk("x0_rd1", bus.rd[XLEN +: XLEN], 32'h0);
        tick();

        for (int r = 1; r < NREGS; r++) begin
            bus.wen = 1'b1; bus.wa = AW'(r); bus.wd = $urandom;
            tick();
        end
        idle();

        // W0 write-to-read latency
        set_ra(0, 5); bus.wen = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF;
        tick();
        idle();
        #1 chk("x5_after_write", bus.rd[0 +: XLEN], 32'hDEADBEEF);
        tick();

        // Writes and marks to x0 are ignored
        bus.ra = '0; bus.wen = 1'b1; bus.wa = '0; bus.wd = 32'h1234;
        bus.mark_en = 1'b1; bus.mark_addr = '0;
        tick();
        idle();
        #1 chk("x0_after_write", bus.rd[0 +: XLEN], 32'h0);
        chk("x0_busy_after_mark", 32'(bus.rd_busy[0]), 32'h0);
        tick();

        // Mark x7, long-latency completion three cycles later
        set_ra(0, 7); bus.mark_en = 1'b1; bus.mark_addr = 5'd7;
        tick();
        idle();
        #1 chk("x7_busy_marked", 32'(bus.rd_busy[0]), 32'h1);
        repeat (3) tick();
        bus.lwen = 1'b1; bus.lwa = 5'd7; bus.lwd = 32'h55;
        tick();
        idle();
        #1 chk("x7_busy_cleared", 32'(bus.rd_busy[0]), 32'h0);
        chk("x7_data", bus.rd[0 +: XLEN], 32'h55);
        tick();

        // Same-cycle mark and clear on x9
        set_ra(0, 9); bus.mark_en = 1'b1; bus.mark_addr = 5'd9;
        bus.lwen = 1'b1; bus.lwa = 5'd9; bus.lwd = 32'h99;
        tick();
        idle();
        #1 chk("x9_busy_mark_wins", 32'(bus.rd_busy[0]), 32'h1);
        chk("x9_data", bus.rd[0 +: XLEN], 32'h99);
        tick();

        // W0/W1 collision on x3 with x4 busy, then reset clears x4
        bus.mark_en = 1'b1; bus.mark_addr = 5'd4;
        tick();
        idle();
        set_ra(0, 3); set_ra(1, 4);
        bus.wen = 1'b1; bus.wa = 5'd3; bus.wd = 32'hA;
        bus.lwen = 1'b1; bus.lwa = 5'd3; bus.lwd = 32'hB;
        tick();
        idle();
        #1 chk("x3_w0_wins", bus.rd[0 +: XLEN], 32'hA);
        chk("wr_conflict_pulse", 32'(bus.wr_conflict), 32'h1);
        chk("x4_busy_before_reset", 32'(bus.rd_busy[1]), 32'h1);
        tick();
        #1 chk("wr_conflict_one_cycle", 32'(bus.wr_conflict), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 chk("x4_busy_after_reset", 32'(bus.rd_busy[1]), 32'h0);
        tick();

        // Randomised traffic, biased to low registers to provoke collisions
        repeat (3000) begin
            reset         = ($urandom_range(0, 99) == 0);
            bus.wen       = $urandom_range(0, 1) == 1;
            bus.wa        = AW'(pick_addr());
            bus.wd        = $urandom;
            bus.lwen      = $urandom_range(0, 2) == 0;
            bus.lwa       = AW'(pick_addr());
            bus.lwd       = $urandom;
            bus.mark_en   = $urandom_range(0, 2) == 0;
            bus.mark_addr = AW'(pick_addr());
            for (int i = 0; i < NRD; i++) set_ra(i, pick_addr());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
